// File: rtl/seq_det_event_logger_if.sv
// Event drain handshake between the logger and its consumer.
// Master presents timestamps; slave accepts them with ready.
interface seq_det_event_logger_if #(
  parameter int TS_W = 16
) ();
  logic            ev_valid;
  logic            ev_ready;
  logic [TS_W-1:0] ev_ts;

  modport master (
    output ev_valid,
    output ev_ts,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_ts,
    output ev_ready
  );
endinterface

// File: rtl/seq_det_event_logger.sv
// Timestamps "101" detector pulses into a FWFT queue drained over
// valid/ready, with saturating event/drop counters and sticky overflow.
module seq_det_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     det_in,
  seq_det_event_logger_if.master   ev,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         ev_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            det;
  logic            pop;
  logic            full;
  logic            push;
  logic            drop;
  logic            wipe;

  assign wipe = rst | clr;
  assign det  = det_in & en;
  assign pop  = ev.ev_ready & (fifo_level != '0);
  assign full = fifo_level == LW'(DEPTH);
  // A pop on a full queue frees the slot the new entry takes.
  assign push = det & (~full | pop);
  assign drop = det & full & ~pop;

  assign ev.ev_valid = fifo_level != '0;
  assign ev.ev_ts    = ev.ev_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!wipe && push) begin
      mem[wr_ptr] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      ts         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      ev_count   <= '0;
      drop_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (en) begin
        ts <= ts + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (det && ev_count != CMAX) begin
        ev_count <= ev_count + 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
        if (drop_count != CMAX) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_event_logger.sv
// Directed bench for seq_det_event_logger with a queue-based reference
// model checked every cycle plus hand-computed spot values.
module tb_seq_det_event_logger;

  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TSM   = (1 << TS_W) - 1;
  localparam int CM    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic det_in = 1'b0;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] ev_count;
  logic [CNT_W-1:0] drop_count;
  logic             ovf;

  seq_det_event_logger_if #(.TS_W(TS_W)) ev ();

  seq_det_event_logger #(
    .TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .det_in(det_in),
    .ev(ev.master),
    .fifo_level(fifo_level), .ev_count(ev_count),
    .drop_count(drop_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of timestamps and plain integer counters.
  int q[$];
  int m_ts = 0;
  int m_evc = 0;
  int m_drc = 0;
  int m_ovf = 0;

  always @(posedge clk) begin
    if (rst || clr) begin
      q.delete();
      m_ts = 0; m_evc = 0; m_drc = 0; m_ovf = 0;
    end else begin
      if (ev.ev_ready && q.size() > 0) void'(q.pop_front());
      if (det_in && en) begin
        if (m_evc < CM) m_evc++;
        if (q.size() < DEPTH) q.push_back(m_ts);
        else begin
          m_ovf = 1;
          if (m_drc < CM) m_drc++;
        end
      end
      if (en) m_ts = (m_ts + 1) & TSM;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", int'(ev.ev_valid), int'(q.size() > 0));
      chk("m_ts", int'(ev.ev_ts), q.size() > 0 ? q[0] : 0);
      chk("m_level", int'(fifo_level), q.size());
      chk("m_evc", int'(ev_count), m_evc);
      chk("m_drc", int'(drop_count), m_drc);
      chk("m_ovf", int'(ovf), m_ovf);
    end
  end

  task automatic tick(input bit e, input bit d, input bit r, input bit c);
    en = e; det_in = d; ev.ev_ready = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  bit [1:0] hist;
  bit [4:0] bits;

  initial begin
    ev.ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (10) tick(1, 0, 0, 0);
    chk("idle_valid", int'(ev.ev_valid), 0);
    chk("idle_ts", int'(ev.ev_ts), 0);
    chk("idle_level", int'(fifo_level), 0);
    chk("idle_evc", int'(ev_count), 0);
    chk("idle_drc", int'(drop_count), 0);
    chk("idle_ovf", int'(ovf), 0);

    // Single event at ts=5
    do_rst();
    repeat (5) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    chk("single_valid", int'(ev.ev_valid), 1);
    chk("single_ts", int'(ev.ev_ts), 5);
    chk("single_evc", int'(ev_count), 1);
    tick(1, 0, 1, 0);
    chk("single_popv", int'(ev.ev_valid), 0);
    chk("single_popl", int'(fifo_level), 0);

    // Detector-driven: serial 1,0,1,0,1 through a Mealy "101" detector
    do_rst();
    hist = 2'b00;
    bits = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      tick(1, (hist == 2'b10) && bits[i], 0, 0);
      hist = {hist[0], bits[i]};
    end
    chk("det_level", int'(fifo_level), 2);
    chk("det_head", int'(ev.ev_ts), 2);
    chk("det_evc", int'(ev_count), 2);
    tick(1, 0, 1, 0);
    chk("det_second", int'(ev.ev_ts), 4);
    tick(1, 0, 1, 0);

    // Overflow: ten detections into an eight-deep queue
    do_rst();
    repeat (10) tick(1, 1, 0, 0);
    chk("ovf_level", int'(fifo_level), 8);
    chk("ovf_drc", int'(drop_count), 2);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_evc", int'(ev_count), 10);
    // Full queue with simultaneous push and pop: ts=10 joins the tail
    tick(1, 1, 1, 0);
    chk("fpp_level", int'(fifo_level), 8);
    chk("fpp_drc", int'(drop_count), 2);
    chk("fpp_head", int'(ev.ev_ts), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_ts", int'(ev.ev_ts), i < 7 ? i + 1 : 10);
      tick(0, 0, 1, 0);
    end
    chk("drain_level", int'(fifo_level), 0);
    chk("drain_ovf", int'(ovf), 1);

    // en gating: det_in ignored and ts held at 11
    tick(0, 1, 0, 0);
    chk("gate_evc", int'(ev_count), 11);
    chk("gate_level", int'(fifo_level), 0);
    tick(1, 1, 0, 0);
    chk("gate_ts", int'(ev.ev_ts), 11);
    tick(1, 0, 1, 0);

    // Timestamp wrap: entries 15 then 0
    do_rst();
    repeat (15) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("wrap_level", int'(fifo_level), 2);
    chk("wrap_first", int'(ev.ev_ts), 15);
    tick(1, 0, 1, 0);
    chk("wrap_second", int'(ev.ev_ts), 0);
    chk("wrap_valid", int'(ev.ev_valid), 1);
    tick(1, 0, 1, 0);

    // Counter saturation: 24 detections, 16 of them dropped
    do_rst();
    repeat (24) tick(1, 1, 0, 0);
    chk("sat_evc", int'(ev_count), 15);
    chk("sat_drc", int'(drop_count), 15);

    // clr with det_in high writes nothing
    tick(1, 1, 0, 1);
    chk("clr_level", int'(fifo_level), 0);
    chk("clr_evc", int'(ev_count), 0);
    chk("clr_drc", int'(drop_count), 0);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_valid", int'(ev.ev_valid), 0);
    tick(1, 1, 0, 0);
    chk("clr_after_lvl", int'(fifo_level), 1);
    chk("clr_after_ts", int'(ev.ev_ts), 0);

    // Mixed traffic against the model
    for (int i = 0; i < 80; i++) begin
      tick(i % 7 != 3, (i % 3 == 0) || (i % 5 == 1), (i % 4) < 2 && i > 20, i == 60);
    end
    repeat (12) tick(1, 0, 1, 0);
    chk("end_level", int'(fifo_level), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_event_logger.md
Name: seq_det_event_logger

Overview:
- Downstream consumer of the serial "101" Mealy detector output pulse `y`.
- Timestamps each detection pulse with a free-running cycle counter and queues the timestamp in a small first-word-fall-through FIFO.
- Drains the queue over a valid/ready interface.
- Keeps a saturating total-detection count, a saturating drop count and a sticky overflow flag, for monitoring and debug.

Parameters:
- TS_W, 16, width of timestamp counter and FIFO entries.
- DEPTH, 8, FIFO entries; power of two, 2..256.
- CNT_W, 16, width of ev_count and drop_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  logging enable; gates timestamp increment and det_in sampling.
- clr  in  1  synchronous soft clear; same effect as rst, lower priority.
- det_in  in  1  detection pulse, driven by detector output y; high one cycle per detection.
- ev_valid  out  1  FIFO head holds a valid timestamp.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_ts  out  TS_W  timestamp at FIFO head; 0 when empty.
- fifo_level  out  $clog2(DEPTH)+1  current number of stored entries.
- ev_count  out  CNT_W  total detections sampled, saturating.
- drop_count  out  CNT_W  detections lost to a full FIFO, saturating.
- ovf  out  1  sticky: at least one drop since last rst/clr.

Behaviour:
- Reset (rst=1 at edge): ts counter, FIFO pointers, fifo_level, ev_count, drop_count and ovf all cleared; ev_valid=0, ev_ts=0.
- Priority: rst > clr > normal operation. On a clr cycle the FIFO is emptied, all counters and ovf are cleared, and det_in and ev_ready are ignored (no pop is performed).
- Timestamp: TS_W-bit ts, +1 each cycle with en=1, held when en=0. Wraps from 2^TS_W-1 to 0 with no flag.
- Sample: a detection occurs when det_in=1 and en=1 at an edge. The recorded value is ts before that edge's increment. det_in with en=0 is ignored entirely (no count, no push).
- ev_count: +1 per detection, including dropped ones. Saturates at 2^CNT_W-1.
- Pop: happens when ev_valid=1 and ev_ready=1 at an edge. The head advances and the next entry appears on ev_ts the following cycle.
- Push: a detection writes ts at the tail when any of these holds:
  - fifo_level < DEPTH;
  - fifo_level == DEPTH and a pop occurs in the same cycle (level unchanged).
- Drop: a detection with fifo_level == DEPTH and no pop is not written. drop_count increments (saturating) and ovf is set.
- Simultaneous push+pop: allowed at any non-empty level; level is unchanged and ordering is preserved.
- Push while empty: ev_valid rises the next cycle (latency 1). No same-cycle bypass; ev_ready while empty has no effect.
- ev_valid = (fifo_level != 0). ev_ts is the head entry when valid and 0 when empty.
- Back-to-back det_in on consecutive cycles: each one is a separate detection; no pulse merging.
- Pointers: $clog2(DEPTH) bits, wrap naturally. fifo_level range is 0..DEPTH.
- ev_valid and ev_ts must stay stable while ev_valid=1 and ev_ready=0.

Test Plan:
- Reset/idle: rst 2 cycles, en=1, det_in=0 for 10 cycles -> ev_valid=0, ev_ts=0, level=0, counts=0, ovf=0.
- Single event: after rst, en=1; det_in=1 at cycle 5 (ts=5) -> ev_valid=1 at cycle 6 with ev_ts=5, ev_count=1. ev_ready=1 one cycle -> level=0, ev_valid=0.
- Detector-driven: serial stream 1,0,1,0,1 into the detector feeding det_in -> two entries, timestamps 2 apart, ev_count=2.
- Overflow: DEPTH=8, ev_ready=0, 10 detections -> level=8, drop_count=2, ovf=1, ev_count=10. Then drain with ev_ready=1 -> the first 8 timestamps come out in order and ovf stays 1.
- Full + simultaneous push/pop: level=8, det_in=1 and ev_ready=1 same cycle -> no drop, level stays 8, new timestamp at tail.
- en gating / wrap / clr: en=0 with det_in=1 -> no change and ts held. TS_W=4: run 20 cycles, detection at ts 15 then 0 -> entries 15,0. clr mid-queue with det_in=1 -> level=0, counts=0, ovf=0, no entry written.
